mtime_counter: RTL and testbench
================================

# mtime_counter

Free-running 64-bit machine timer that produces the `mtime` value consumed by the timer-compare block and the timer interrupt path. It counts prescaled clock ticks, lets the CPU load either 32-bit half through active-low write strobes, and returns both halves for CPU readback. Optionally, it latches the high word on a low-word read so software reads a coherent 64-bit value.

## Interface
Parameters:
- `PRESCALE`, default 1: number of `clk` cycles per `mtime` increment; legal range 1..65536.
- `PSC_W`, default 16: width of the prescaler counter; must satisfy 2^`PSC_W` ≥ `PRESCALE`.

Ports:
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `wrh_n` in 1: active-low write strobe for `mtime[63:32]`.
- `wrl_n` in 1: active-low write strobe for `mtime[31:0]`.
- `rdl_n` in 1: active-low read strobe for the low word; drives the snapshot.
- `stop` in 1: when high, freezes both the counter and the prescaler (debug halt).
- `mtime_o` in 32: write data from the CPU.
- `mtime` out 64: current counter value, registered.
- `mtimeh_i` out 32: high-word readback to the CPU.
- `mtimel_i` out 32: low-word readback to the CPU; always equals `mtime[31:0]`.
- `tick` out 1: registered one-cycle pulse, high in each cycle in which `mtime` has just incremented.

## Operation
- Prescaler `psc` (`PSC_W` bits) counts 0..`PRESCALE`-1.
- An increment event occurs on an edge where all of the following hold: `psc == PRESCALE-1`, `stop == 0`, `wrh_n == 1` and `wrl_n == 1`.
  - On that edge: `psc` ← 0, `mtime` ← `mtime` + 1 (64-bit, wraps 0xFFFF_FFFF_FFFF_FFFF → 0), `tick` ← 1.
  - On every other edge: `tick` ← 0.
- Otherwise, with `stop == 0` and no write, `psc` ← `psc` + 1.
- With `stop == 1`, `psc` and `mtime` hold; a write still takes effect.
- Write cycle (either strobe low):
  - The addressed half(s) load `mtime_o`; the unaddressed half holds.
  - The increment is suppressed for the whole register and `psc` ← 0.
  - `wrh_n` and `wrl_n` both low loads both halves with the same `mtime_o`.
- Carry from the low to the high half is a full 64-bit add; there is no per-half wrap.
- With `PRESCALE == 1`, `psc` stays 0 and every non-stopped, non-write edge increments.

## Timing
- Reset values, all applied asynchronously while `rst` is high: `mtime` = 0, `psc` = 0, `tick` = 0, snapshot = 0; therefore `mtimeh_i` = 0 and `mtimel_i` = 0.
- Write latency is 1 cycle: a strobe sampled low at edge N makes the new value visible on `mtime` after edge N.
- The first increment after a write or reset release occurs on the `PRESCALE`-th non-stopped edge.
- `tick` is high for exactly one cycle per increment and is never high on a write edge.
- Asserting `rst` mid-count clears all state immediately, with no clock edge required. Counting resumes from 0 on the first edge after deassertion.
- `mtimel_i` is combinational from the `mtime` register.

## Configuration
Macro: `MTIME_SNAPSHOT_EN`.

Defined:
- A 32-bit snapshot register captures `mtime[63:32]` (its pre-edge value) on every edge where `rdl_n == 0`.
- A write with `wrh_n == 0` also loads the snapshot with `mtime_o`.
- `mtimeh_i` = snapshot. Software reads low, then high, and gets a coherent value.

Undefined:
- No snapshot register; `rdl_n` is ignored.
- `mtimeh_i` = `mtime[63:32]` directly.

## Test plan
- Reset, then release with `PRESCALE` = 1 and `stop` = 0 → `mtime` reads 0, 1, 2, 3 on consecutive cycles, and `tick` is high every cycle after the first edge.
- `PRESCALE` = 4 → `mtime` increments every 4th edge with a 1-cycle `tick`. Hold `stop` = 1 for 10 cycles → `mtime`, `psc` and `tick` (0) freeze; counting resumes where it left off.
- Write low 0xFFFF_FFFE with high 0, `PRESCALE` = 1 → next cycle `mtime` = 0x0000_0000_FFFF_FFFE; two cycles later `mtime` = 0x0000_0001_0000_0000.
- Both strobes low with `mtime_o` = 0xFFFF_FFFF → `mtime` = 0xFFFF_FFFF_FFFF_FFFF and no `tick` on the write edge; the next increment gives `mtime` = 0 with `tick` = 1.
- Snapshot check:
  - Setup: `mtime` = 0x0000_0000_FFFF_FFFF; pulse `rdl_n` on the edge that increments to 0x0000_0001_0000_0000.
  - With `MTIME_SNAPSHOT_EN`: `mtimeh_i` stays 0 until the next `rdl_n` pulse, then reads 1.
  - Without it: `mtimeh_i` reads 1 immediately.
- Assert `rst` asynchronously mid-count at `mtime` = 0x1234 with `PRESCALE` = 4 and `psc` = 2 → `mtime`, `mtimeh_i`, `mtimel_i` and `tick` go to 0 before the next clock edge; after release the first increment occurs 4 edges later.

Source files
------------

// File: rtl/mtime_counter.sv
// ---------------------------------------------------------------------------
// mtime_counter
//
// Free-running 64-bit machine timer. A prescaler divides clk so that mtime
// advances once every PRESCALE cycles. The CPU can load either 32-bit half
// through active-low write strobes and read both halves back.
//
// Build option:
//   MTIME_SNAPSHOT_EN  When defined, the high word returned on mtimeh_i is a
//                      snapshot taken on every low-word read (rdl_n low), so
//                      a low-then-high read sequence is coherent across a
//                      carry. When undefined, rdl_n is ignored and mtimeh_i
//                      is the live high word.
//
// Parameters:
//   PRESCALE  clk cycles per mtime increment, 1..65536
//   PSC_W     prescaler width, 2**PSC_W >= PRESCALE
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   wrh_n     write strobe for mtime[63:32] (active low)
//   wrl_n     write strobe for mtime[31:0]  (active low)
//   rdl_n     low-word read strobe (active low), drives the snapshot
//   stop      debug halt: freezes counter and prescaler, writes still land
//   mtime_o   32-bit write data from the CPU
//   mtime     registered 64-bit counter value
//   mtimeh_i  high-word readback
//   mtimel_i  low-word readback, always mtime[31:0]
//   tick      one-cycle pulse after each increment
// ---------------------------------------------------------------------------
module mtime_counter #(
   parameter int unsigned PRESCALE = 1,
   parameter int unsigned PSC_W    = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wrh_n,
   input  logic        wrl_n,
   input  logic        rdl_n,
   input  logic        stop,
   input  logic [31:0] mtime_o,
   output logic [63:0] mtime,
   output logic [31:0] mtimeh_i,
   output logic [31:0] mtimel_i,
   output logic        tick
);

   if (PRESCALE < 1 || PRESCALE > 65536) begin : g_prescale_range
      $error("mtime_counter: PRESCALE must be in 1..65536");
   end

   if (PSC_W < 1 || PSC_W > 32) begin : g_psc_w_range
      $error("mtime_counter: PSC_W must be in 1..32");
   end

   if ((longint'(1) << PSC_W) < longint'(PRESCALE)) begin : g_psc_w_fit
      $error("mtime_counter: PSC_W too narrow for PRESCALE");
   end

   // Terminal count of the prescaler; the increment happens when psc sits here.
   localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

   logic [PSC_W-1:0] psc;
   logic             wr_any;
   logic             psc_tc;
   logic             inc;

   assign wr_any = !wrh_n || !wrl_n;
   assign psc_tc = (psc == PSC_LAST);
   // Any write suppresses the increment for the whole 64-bit register.
   assign inc    = psc_tc && !stop && !wr_any;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtime <= '0;
         psc   <= '0;
         tick  <= 1'b0;
      end else begin
         tick <= inc;
         if (wr_any) begin
            // Writes restart the prescale interval even while stopped.
            psc <= '0;
            if (!wrh_n) mtime[63:32] <= mtime_o;
            if (!wrl_n) mtime[31:0]  <= mtime_o;
         end else if (!stop) begin
            if (psc_tc) begin
               psc   <= '0;
               mtime <= mtime + 64'd1;
            end else begin
               psc <= psc + 1'b1;
            end
         end
      end
   end

   assign mtimel_i = mtime[31:0];

`ifdef MTIME_SNAPSHOT_EN
   logic [31:0] snap;

   // The snapshot takes the high word as it was before the edge, so a read
   // that coincides with a carry still pairs with the old low word. A high
   // write wins over a simultaneous read so the readback matches what was
   // just written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap <= '0;
      end else if (!wrh_n) begin
         snap <= mtime_o;
      end else if (!rdl_n) begin
         snap <= mtime[63:32];
      end
   end

   assign mtimeh_i = snap;
`else
   logic unused_rdl_n;

   assign unused_rdl_n = rdl_n;
   assign mtimeh_i     = mtime[63:32];
`endif

endmodule

// File: tb/tb_mtime_counter.sv
// ---------------------------------------------------------------------------
// tb_mtime_counter
//
// Drives two timer instances (PRESCALE 1 and PRESCALE 4) from the same
// stimulus. A behavioural model predicts every cycle; predictions are queued
// at the falling edge when inputs are applied and compared just after the
// following rising edge. Directed checks cover the specific scenarios of
// interest (carry, wrap, stop, snapshot, asynchronous reset).
// ---------------------------------------------------------------------------
module tb_mtime_counter;

   logic        clk;
   logic        rst;
   logic        wrh_n;
   logic        wrl_n;
   logic        rdl_n;
   logic        stop;
   logic [31:0] mtime_o;

   logic [63:0] mtime_1;
   logic [31:0] mtimeh_1;
   logic [31:0] mtimel_1;
   logic        tick_1;
   logic [63:0] mtime_4;
   logic [31:0] mtimeh_4;
   logic [31:0] mtimel_4;
   logic        tick_4;

   mtime_counter #(.PRESCALE(1), .PSC_W(16)) dut1 (
      .clk      (clk),
      .rst      (rst),
      .wrh_n    (wrh_n),
      .wrl_n    (wrl_n),
      .rdl_n    (rdl_n),
      .stop     (stop),
      .mtime_o  (mtime_o),
      .mtime    (mtime_1),
      .mtimeh_i (mtimeh_1),
      .mtimel_i (mtimel_1),
      .tick     (tick_1)
   );

   mtime_counter #(.PRESCALE(4), .PSC_W(2)) dut4 (
      .clk      (clk),
      .rst      (rst),
      .wrh_n    (wrh_n),
      .wrl_n    (wrl_n),
      .rdl_n    (rdl_n),
      .stop     (stop),
      .mtime_o  (mtime_o),
      .mtime    (mtime_4),
      .mtimeh_i (mtimeh_4),
      .mtimel_i (mtimel_4),
      .tick     (tick_4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          pre [2] = '{1, 4};
   logic [63:0] mm  [2];
   int          ps  [2];
   logic        tk  [2];
   logic [31:0] sn  [2];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mm[k] = '0;
         ps[k] = 0;
         tk[k] = 1'b0;
         sn[k] = '0;
      end
   endtask

   task automatic model_step(input logic h_n, input logic l_n, input logic r_n,
                             input logic s, input logic [31:0] d);
      logic [31:0] hi_before;
      for (int k = 0; k < 2; k++) begin
         hi_before = mm[k][63:32];
         tk[k] = 1'b0;
         if (!h_n || !l_n) begin
            if (!h_n) mm[k][63:32] = d;
            if (!l_n) mm[k][31:0]  = d;
            ps[k] = 0;
         end else if (!s) begin
            if (ps[k] == pre[k] - 1) begin
               mm[k] = mm[k] + 64'd1;
               ps[k] = 0;
               tk[k] = 1'b1;
            end else begin
               ps[k] = ps[k] + 1;
            end
         end
         if (!h_n)      sn[k] = d;
         else if (!r_n) sn[k] = hi_before;
      end
   endtask

   function automatic logic [31:0] exp_hi(input int k);
`ifdef MTIME_SNAPSHOT_EN
      return sn[k];
`else
      return mm[k][63:32];
`endif
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [63:0] m1;
      logic        t1;
      logic [31:0] h1;
      logic [63:0] m4;
      logic        t4;
      logic [31:0] h4;
   } exp_t;

   exp_t sb[$];
   exp_t e_cur;

   task automatic push_exp();
      exp_t e;
      e.m1 = mm[0];
      e.t1 = tk[0];
      e.h1 = exp_hi(0);
      e.m4 = mm[1];
      e.t4 = tk[1];
      e.h4 = exp_hi(1);
      sb.push_back(e);
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() != 0) begin
         e_cur = sb.pop_front();
         chk("sb_mtime1",  mtime_1,          e_cur.m1);
         chk("sb_tick1",   64'(tick_1),      64'(e_cur.t1));
         chk("sb_mtimeh1", 64'(mtimeh_1),    64'(e_cur.h1));
         chk("sb_mtimel1", 64'(mtimel_1),    64'(e_cur.m1[31:0]));
         chk("sb_mtime4",  mtime_4,          e_cur.m4);
         chk("sb_tick4",   64'(tick_4),      64'(e_cur.t4));
         chk("sb_mtimeh4", 64'(mtimeh_4),    64'(e_cur.h4));
         chk("sb_mtimel4", 64'(mtimel_4),    64'(e_cur.m4[31:0]));
      end
   end

   // ---------------- stimulus helpers ----------------
   // Inputs change at the falling edge; the task returns 2 time units after
   // the rising edge so directed checks see the post-edge outputs.
   task automatic cycle(input logic h_n, input logic l_n, input logic r_n,
                        input logic s, input logic [31:0] d);
      @(negedge clk);
      wrh_n   = h_n;
      wrl_n   = l_n;
      rdl_n   = r_n;
      stop    = s;
      mtime_o = d;
      model_step(h_n, l_n, r_n, s, d);
      push_exp();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mtime1"},  mtime_1,        64'h0);
      chk({tag, "_mtimeh1"}, 64'(mtimeh_1),  64'h0);
      chk({tag, "_mtimel1"}, 64'(mtimel_1),  64'h0);
      chk({tag, "_tick1"},   64'(tick_1),    64'h0);
      chk({tag, "_mtime4"},  mtime_4,        64'h0);
      chk({tag, "_mtimeh4"}, 64'(mtimeh_4),  64'h0);
      chk({tag, "_mtimel4"}, 64'(mtimel_4),  64'h0);
      chk({tag, "_tick4"},   64'(tick_4),    64'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- test sequence ----------------
   initial begin
      rst     = 1'b1;
      wrh_n   = 1'b1;
      wrl_n   = 1'b1;
      rdl_n   = 1'b1;
      stop    = 1'b0;
      mtime_o = 32'h0;
      model_reset();

      // Reset state, before any clock edge
      #2;
      chk_all_zero("rst_init");

      // Release between edges, then count with PRESCALE 1 and 4
      @(posedge clk);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      chk("rel_mtime1_0", mtime_1, 64'd0);
      for (int i = 1; i <= 3; i++) begin
         idle(1);
         chk($sformatf("cnt1_%0d", i), mtime_1, 64'(i));
         chk($sformatf("cnt1_tick_%0d", i), 64'(tick_1), 64'd1);
      end
      idle(1);
      chk("p4_first_inc", mtime_4, 64'd1);
      chk("p4_first_tick", 64'(tick_4), 64'd1);
      idle(1);
      chk("p4_tick_one_cycle", 64'(tick_4), 64'd0);
      idle(5);
      chk("p4_after10", mtime_4, 64'd2);

      // Stop for 10 cycles: everything holds, tick stays low
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0);
         chk("stop_mtime1", mtime_1, 64'd10);
         chk("stop_mtime4", mtime_4, 64'd2);
         chk("stop_tick1",  64'(tick_1), 64'd0);
      end
      idle(1);
      chk("resume_p4_hold", mtime_4, 64'd2);
      chk("resume_mtime1", mtime_1, 64'd11);
      idle(1);
      chk("resume_p4_inc", mtime_4, 64'd3);
      chk("resume_p4_tick", 64'(tick_4), 64'd1);

      // Low-to-high carry
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE);
      chk("carry_load", mtime_1, 64'h0000_0000_FFFF_FFFE);
      chk("carry_load_tick", 64'(tick_1), 64'd0);
      idle(2);
      chk("carry_result", mtime_1, 64'h0000_0001_0000_0000);

      // Both strobes low, then 64-bit wrap
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
      chk("wr_both", mtime_1, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("wr_both_tick1", 64'(tick_1), 64'd0);
      chk("wr_both_tick4", 64'(tick_4), 64'd0);
      idle(1);
      chk("wrap_mtime1", mtime_1, 64'h0);
      chk("wrap_tick1", 64'(tick_1), 64'd1);

      // Snapshot across a carry
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("snap_mtime1", mtime_1, 64'h0000_0001_0000_0000);
`ifdef MTIME_SNAPSHOT_EN
      chk("snap_hi_first", 64'(mtimeh_1), 64'd0);
      idle(1);
      chk("snap_hi_hold", 64'(mtimeh_1), 64'd0);
`else
      chk("snap_hi_first", 64'(mtimeh_1), 64'd1);
      idle(1);
      chk("snap_hi_hold", 64'(mtimeh_1), 64'd1);
`endif
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("snap_hi_second", 64'(mtimeh_1), 64'd1);

      // Asynchronous reset mid-count: mtime 0x1234, PRESCALE 4 psc = 2
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1234);
      idle(2);
      chk("pre_rst_mtime4", mtime_4, 64'h1234);
      #1;
      rst = 1'b1;
      #1;
      chk_all_zero("async_rst");
      @(posedge clk);
      #2;
      chk("rst_hold_mtime1", mtime_1, 64'h0);
      rst = 1'b0;
      model_reset();
      idle(3);
      chk("post_rst_p4_hold", mtime_4, 64'h0);
      chk("post_rst_p4_notick", 64'(tick_4), 64'd0);
      idle(1);
      chk("post_rst_p4_inc", mtime_4, 64'h1);
      chk("post_rst_p4_tick", 64'(tick_4), 64'd1);

      // Random traffic, checked by the scoreboard only
      for (int i = 0; i < 60; i++) begin
         cycle(($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0),
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0),
               $urandom());
      end
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
